// File: rtl/led_step_seq.sv
// LED step sequencer: advances a rotate-left/right, ping-pong or blink-all pattern per accepted tick.
// Latency: one cycle from an accepted tick to the updated led_out/cycle_done; busy follows the state register.
// No backpressure: ticks arriving while en is low are dropped and never queued.
module led_step_seq #(
  parameter int LED_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_in,
  input  logic             en,
  input  logic             soft_clr,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led_out,
  output logic             cycle_done,
  output logic             busy
);

  localparam int PW = $clog2(LED_W);
  localparam logic [PW-1:0] POS_MAX = PW'(LED_W - 1);
  localparam logic [PW-1:0] POS_ZERO = '0;

  localparam logic [1:0] M_ROT_L = 2'd0;
  localparam logic [1:0] M_ROT_R = 2'd1;
  localparam logic [1:0] M_PING  = 2'd2;
  localparam logic [1:0] M_BLINK = 2'd3;

  // Direction of the ping-pong sweep: 0 walks toward the top LED, 1 walks back.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              phase_q, phase_d;
  logic [1:0]        cur_mode_q, cur_mode_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              done_q, done_d;
  logic              acc;

  assign acc        = tick_in & en;
  assign led_out    = led_q;
  assign cycle_done = done_q;
  assign busy       = (state_q == RUN);

  // Next-state: clear has priority, then restart on entry/mode change, else step the active pattern.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    phase_d    = phase_q;
    cur_mode_d = cur_mode_q;
    led_d      = led_q;
    done_d     = 1'b0;

    if (soft_clr) begin
      state_d    = IDLE;
      pos_d      = '0;
      dir_d      = DIR_UP;
      phase_d    = 1'b0;
      cur_mode_d = 2'd0;
      led_d      = '0;
    end else if (acc) begin
      if (state_q == IDLE || mode != cur_mode_q) begin
        // (Re)start: load the first frame of the newly sampled mode.
        state_d    = RUN;
        cur_mode_d = mode;
        pos_d      = '0;
        dir_d      = DIR_UP;
        phase_d    = 1'b1;
        led_d      = '0;
        case (mode)
          M_ROT_R: led_d[LED_W-1] = 1'b1;
          M_BLINK: led_d          = '1;
          default: led_d[0]       = 1'b1;
        endcase
      end else begin
        case (cur_mode_q)
          M_ROT_L, M_ROT_R: begin
            pos_d  = (pos_q == POS_MAX) ? POS_ZERO : pos_q + 1'b1;
            done_d = (pos_q == POS_MAX);
            led_d  = '0;
            if (cur_mode_q == M_ROT_L) led_d[pos_d] = 1'b1;
            else                       led_d[POS_MAX - pos_d] = 1'b1;
          end
          M_PING: begin
            if (dir_q == DIR_UP) begin
              pos_d = pos_q + 1'b1;
              if (pos_d == POS_MAX) dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q - 1'b1;
              if (pos_d == POS_ZERO) begin
                dir_d  = DIR_UP;
                done_d = 1'b1;
              end
            end
            led_d        = '0;
            led_d[pos_d] = 1'b1;
          end
          default: begin
            // Blink-all: a period ends when the display turns back on.
            phase_d = ~phase_q;
            led_d   = phase_d ? '1 : '0;
            done_d  = phase_d;
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      phase_q    <= 1'b0;
      cur_mode_q <= 2'd0;
      led_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      cur_mode_q <= cur_mode_d;
      led_q      <= led_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_led_step_seq.sv
// Bench for led_step_seq: directed sequences plus random stimulus checked against a step-count model.
// The model tracks "ticks since pattern start" and derives the frame and period end arithmetically.
// Every checked cycle compares led_out, cycle_done and busy one delta after the rising edge.
module tb_led_step_seq;

  localparam int W = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          tick_in;
  logic          en;
  logic          soft_clr;
  logic [1:0]    mode;
  logic [W-1:0]  led_out;
  logic          cycle_done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: running flag, active mode, ticks accepted since (re)start.
  bit m_run  = 1'b0;
  int m_mode = 0;
  int m_k    = 0;
  bit m_done = 1'b0;

  led_step_seq #(.LED_W(W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tick_in    (tick_in),
    .en         (en),
    .soft_clr   (soft_clr),
    .mode       (mode),
    .led_out    (led_out),
    .cycle_done (cycle_done),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int period(input int md);
    case (md)
      0, 1:    return W;
      2:       return 2 * (W - 1);
      default: return 2;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_led();
    logic [W-1:0] v;
    int p;
    v = '0;
    if (!m_run) return v;
    case (m_mode)
      0: v[m_k % W] = 1'b1;
      1: v[W - 1 - (m_k % W)] = 1'b1;
      2: begin
        p = m_k % (2 * (W - 1));
        if (p <= W - 1) v[p] = 1'b1;
        else            v[2 * (W - 1) - p] = 1'b1;
      end
      default: v = ((m_k % 2) == 0) ? '1 : '0;
    endcase
    return v;
  endfunction

  task automatic model_step(input logic t, input logic e, input logic c,
                            input logic r, input logic [1:0] md);
    m_done = 1'b0;
    if (!r || c) begin
      m_run = 1'b0; m_mode = 0; m_k = 0;
    end else if (t && e) begin
      if (!m_run || int'(md) != m_mode) begin
        m_run = 1'b1; m_mode = int'(md); m_k = 0;
      end else begin
        m_k++;
        if ((m_k % period(m_mode)) == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare all outputs.
  task automatic cyc(input logic t, input logic e, input logic c,
                     input logic r, input logic [1:0] md);
    tick_in = t; en = e; soft_clr = c; sys_rst_n = r; mode = md;
    @(posedge sys_clk);
    #1;
    model_step(t, e, c, r, md);
    chk("led", 32'(led_out), 32'(exp_led()));
    chk("done", 32'(cycle_done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_run));
  endtask

  // Tick followed by quiet cycles; returns the frame and pulse seen right after the tick.
  task automatic tick_gap(input logic [1:0] md, input int gap,
                          output logic [W-1:0] led_seen, output logic done_seen);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, md);
    led_seen  = led_out;
    done_seen = cycle_done;
    for (int g = 1; g < gap; g++) cyc(1'b0, 1'b1, 1'b0, 1'b1, md);
  endtask

  initial begin
    logic [W-1:0] seq_rl [6];
    logic [W-1:0] seq_pp [8];
    logic [W-1:0] seq_bl [4];
    logic [W-1:0] lv;
    logic         dv;
    int           done_cnt;
    logic [1:0]   rmode;

    seq_rl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    seq_pp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    seq_bl = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};

    // Reset state.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Rotate-left, ticks 10 cycles apart; period ends with the 5th tick.
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick_gap(2'd0, 10, lv, dv);
      chk("rotl_seq", 32'(lv), 32'(seq_rl[i]));
      chk("rotl_done", 32'(dv), (i == 4) ? 32'd1 : 32'd0);
    end

    // Ping-pong (restarts from rotate-left); period ends with the 7th tick.
    for (int i = 0; i < 8; i++) begin
      tick_gap(2'd2, 3, lv, dv);
      chk("ping_seq", 32'(lv), 32'(seq_pp[i]));
      chk("ping_done", 32'(dv), (i == 6) ? 32'd1 : 32'd0);
    end

    // Blink-all; period ends with the 3rd tick.
    for (int i = 0; i < 4; i++) begin
      tick_gap(2'd3, 2, lv, dv);
      chk("blink_seq", 32'(lv), 32'(seq_bl[i]));
      chk("blink_done", 32'(dv), (i == 2) ? 32'd1 : 32'd0);
    end

    // Rotate-right at 0100, ticks with en low are dropped.
    tick_gap(2'd1, 2, lv, dv);
    tick_gap(2'd1, 2, lv, dv);
    chk("rotr_pos", 32'(lv), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    end
    chk("en_hold", 32'(led_out), 32'b0100);
    tick_gap(2'd1, 2, lv, dv);
    chk("en_resume", 32'(lv), 32'b0010);

    // Mode change without a tick has no effect; the next tick restarts.
    tick_gap(2'd0, 2, lv, dv);
    tick_gap(2'd0, 2, lv, dv);
    tick_gap(2'd0, 2, lv, dv);
    chk("rotl_0100", 32'(lv), 32'b0100);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    chk("mode_no_tick", 32'(led_out), 32'b0100);
    tick_gap(2'd1, 2, lv, dv);
    chk("mode_restart", 32'(lv), 32'b1000);
    chk("mode_restart_done", 32'(dv), 32'd0);

    // Reset mid-run, then soft_clr coincident with a tick.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("midrst_led", 32'(led_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick_gap(2'd0, 2, lv, dv);
    chk("after_rst", 32'(lv), 32'b0001);
    tick_gap(2'd0, 2, lv, dv);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    chk("clr_led", 32'(led_out), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    tick_gap(2'd0, 2, lv, dv);
    chk("after_clr", 32'(lv), 32'b0001);

    // Random traffic, including back-to-back ticks and occasional mode changes.
    rmode = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) rmode = 2'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 99) < 35),
          1'($urandom_range(0, 99) < 85),
          1'($urandom_range(0, 999) < 15),
          1'($urandom_range(0, 999) >= 10),
          rmode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
